// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART instruction-memory boot loader.
package loader_pkg;

  // Byte that opens a load frame unless the instance overrides it
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame parser states; CHK is reachable only when LOADER_CHECKSUM_EN is defined
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CNT_L = 3'd1,
    CNT_H = 3'd2,
    DAT_L = 3'd3,
    DAT_H = 3'd4,
    CHK   = 3'd5,
    FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/instr_mem_loader.sv
// UART boot loader: turns a framed byte stream into sequential 16-bit
// instruction-memory writes from address 0, holding the CPU in reset meanwhile.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 8-bit sum byte.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam int unsigned         IDX_W      = ADDR_W + 1;
  localparam int unsigned         CNT_W      = 16;
  localparam logic [IDX_W-1:0]    WORD_LIMIT = IDX_W'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0]   ADDR_MAX   = '1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lo_q        <= '0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Frame parser: next state plus next values of every register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (rx_vld && state_q != IDLE && state_q != CHK && state_q != FIN)
      csum_d = csum_q + rx_data;
`endif

    // Address advances the cycle after a write pulse and saturates at the top
    if (wr_en_q && wr_addr_q != ADDR_MAX)
      wr_addr_d = wr_addr_q + ADDR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (rx_vld && rx_data == SYNC_BYTE) begin
          state_d     = CNT_L;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_rst_n_d = 1'b0;
          wr_addr_d   = '0;
          idx_d       = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      CNT_L: begin
        if (rx_vld) begin
          cnt_d   = {cnt_q[15:8], rx_data};
          state_d = CNT_H;
        end
      end
      CNT_H: begin
        if (rx_vld) begin
          cnt_d   = {rx_data, cnt_q[7:0]};
          state_d = ({rx_data, cnt_q[7:0]} == 16'd0) ? FIN : DAT_L;
        end
      end
      DAT_L: begin
        if (rx_vld) begin
          lo_d    = rx_data;
          state_d = DAT_H;
        end
      end
      DAT_H: begin
        if (rx_vld) begin
          cnt_d = cnt_q - 16'(1);
          // Words beyond memory capacity are consumed but dropped
          if (idx_q < WORD_LIMIT) begin
            wr_en_d   = 1'b1;
            wr_data_d = {rx_data, lo_q};
            idx_d     = idx_q + IDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (cnt_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = FIN;
`endif
          end else begin
            state_d = DAT_L;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_vld) begin
          if (rx_data != csum_q) err_d = 1'b1;
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        done_d      = 1'b1;
        cpu_rst_n_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frames plus randomized
// frames compared against a frame-level reference model.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_instr_mem_loader;

  localparam int unsigned TB_ADDR_W = 2;
  localparam int unsigned CAP       = 1 << TB_ADDR_W;

  logic                 clk;
  logic                 rst_n;
  logic                 rx_vld;
  logic [7:0]           rx_data;
  logic                 wr_en;
  logic [TB_ADDR_W-1:0] wr_addr;
  logic [15:0]          wr_data;
  logic                 cpu_rst_n;
  logic                 done;
  logic                 err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] fw[$];
  bit          use_gaps;

  instr_mem_loader #(.ADDR_W(TB_ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every memory write the DUT presents
  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_q.push_back('{int'(wr_addr), int'(wr_data)});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic gap();
    if (use_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wr_en"},     32'(wr_en),     32'd0);
    check({tag, ".wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, ".wr_data"},   32'(wr_data),   32'd0);
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".err"},       32'(err),       32'd0);
  endtask

  // Send one frame carrying fw[] and compare against the model
  task automatic run_frame(input string tag, input bit bad_csum);
    int          n;
    int          exp_n;
    int          k;
    bit          exp_err;
    logic [7:0]  sum;
    logic [15:0] w;
    n     = fw.size();
    sum   = 8'h00;
    wr_q.delete();
    gap();
    send_byte(8'hA5);
    check({tag, ".hold_cpu"},  32'(cpu_rst_n), 32'd0);
    check({tag, ".done_clr"},  32'(done),      32'd0);
    check({tag, ".err_clr"},   32'(err),       32'd0);
    gap(); send_byte(8'(n));       sum += 8'(n);
    gap(); send_byte(8'(n >> 8));  sum += 8'(n >> 8);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      gap(); send_byte(w[7:0]);  sum += w[7:0];
      gap(); send_byte(w[15:8]); sum += w[15:8];
    end
    exp_err = (n > CAP);
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) begin
      gap();
      send_byte(bad_csum ? (sum ^ 8'h5C) : sum);
      if (bad_csum) exp_err = 1'b1;
    end
`else
    if (bad_csum) exp_err = exp_err;
`endif
    if (n > 0) check({tag, ".cpu_held_mid"}, 32'(cpu_rst_n), 32'd0);
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".done"},      32'(done),      32'd1);
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, ".err"},       32'(exp_err),   32'(err));
    exp_n = (n > CAP) ? CAP : n;
    check({tag, ".n_writes"},  32'(wr_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_q.size(); i++) begin
      check({tag, ".addr"}, 32'(wr_q[i].addr), 32'(i));
      check({tag, ".data"}, 32'(wr_q[i].data), 32'(fw[i]));
    end
  endtask

  initial begin
    int          n;
    logic [7:0]  b;
    rst_n    = 1'b0;
    rx_vld   = 1'b0;
    rx_data  = 8'h00;
    use_gaps = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Non-sync bytes in IDLE leave everything at reset values
    wr_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    repeat (2) @(negedge clk);
    check_idle_outputs("idle_junk");
    check("idle_junk.writes", 32'(wr_q.size()), 32'd0);

    // Basic two-word frame, back-to-back bytes
    fw = '{16'h1234, 16'hABCD};
    run_frame("basic", 1'b0);

    // Zero-length frame: done exactly two cycles after the CNT_H strobe
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("zero.done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("zero.done",      32'(done),      32'd1);
    check("zero.cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("zero.err",       32'(err),       32'd0);
    check("zero.writes",    32'(wr_q.size()), 32'd0);

    // Sync byte inside a frame is plain data
    fw = '{16'hA5A5};
    run_frame("sync_as_data", 1'b0);

    // Overflow: five words into a four-word memory
    fw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_frame("overflow", 1'b0);

    // Sticky done/err survive junk bytes in IDLE
    send_byte(8'h17); send_byte(8'h00);
    check("sticky.done", 32'(done), 32'd1);
    check("sticky.err",  32'(err),  32'd1);

    // Reset mid-frame after the low byte of word 1
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.writes", 32'(wr_q.size()), 32'd0);
    fw = '{16'h1234, 16'hABCD};
    run_frame("after_rst", 1'b0);

`ifdef LOADER_CHECKSUM_EN
    fw = '{16'h2010};
    run_frame("csum_good", 1'b0);
    fw = '{16'h2010};
    run_frame("csum_bad", 1'b1);
`endif

    // Randomized frames with random spacing and junk between them
    for (int f = 0; f < 24; f++) begin
      use_gaps = ($urandom_range(0, 1) == 1);
      n = $urandom_range(0, 7);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
      run_frame("rand", ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
